regfile_mp: RTL and testbench



---
 rtl/regfile_mp.sv | 75 +++++++
 tb/tb_regfile_mp.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file with fixed-priority writes and a busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_RD*AW-1:0]     rs_addr_i,
  output logic [NUM_RD*XLEN-1:0]   rs_data_o,
  output logic [NUM_RD-1:0]        rs_busy_o,
  input  logic [NUM_WR-1:0]        rd_we_i,
  input  logic [NUM_WR*AW-1:0]     rd_addr_i,
  input  logic [NUM_WR*XLEN-1:0]   rd_data_i,
  input  logic                     sb_set_i,
  input  logic [AW-1:0]            sb_addr_i
);

  logic [XLEN-1:0]    regs [1:NREGS-1];
  logic [NREGS-1:1]   busy;

  // NOTE: the array is reset because architectural state must read zero
  // after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 1; r < NREGS; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        // NOTE: later non-blocking assignments to the same target win, so
        // iterating ports upward gives the highest-indexed port priority.
        for (int w = 0; w < NUM_WR; w++) begin
          if (rd_we_i[w] && rd_addr_i[w*AW +: AW] == AW'(r)) begin
            regs[r] <= rd_data_i[w*XLEN +: XLEN];
            busy[r] <= 1'b0;
          end
        end
        // A new producer issued this cycle overrides the retiring one.
        if (sb_set_i && sb_addr_i == AW'(r)) busy[r] <= 1'b1;
      end
    end
  end

  // NOTE: every output gets a default before the loops so no latch is inferred.
  always_comb begin
    rs_data_o = '0;
    rs_busy_o = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int r = 1; r < NREGS; r++) begin
        if (rs_addr_i[p*AW +: AW] == AW'(r)) begin
          rs_data_o[p*XLEN +: XLEN] = regs[r];
          rs_busy_o[p]              = busy[r];
        end
      end
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++) begin
        if (rd_we_i[w] && rs_addr_i[p*AW +: AW] != '0 &&
            rd_addr_i[w*AW +: AW] == rs_addr_i[p*AW +: AW]) begin
          rs_data_o[p*XLEN +: XLEN] = rd_data_i[w*XLEN +: XLEN];
          rs_busy_o[p]              = 1'b0;
        end
      end
`endif
    end
    // Outputs are held at zero for the whole reset window, bypass included.
    if (!rst_n_i) begin
      rs_data_o = '0;
      rs_busy_o = '0;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// compared against an array-based reference model of the architectural state.
module tb_regfile_mp;
  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int AW     = 5;

  logic                   clk_i = 1'b0;
  logic                   rst_n_i;
  logic [NUM_RD*AW-1:0]   rs_addr_i;
  logic [NUM_RD*XLEN-1:0] rs_data_o;
  logic [NUM_RD-1:0]      rs_busy_o;
  logic [NUM_WR-1:0]      rd_we_i;
  logic [NUM_WR*AW-1:0]   rd_addr_i;
  logic [NUM_WR*XLEN-1:0] rd_data_i;
  logic                   sb_set_i;
  logic [AW-1:0]          sb_addr_i;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .rs_addr_i(rs_addr_i), .rs_data_o(rs_data_o), .rs_busy_o(rs_busy_o),
    .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
    .sb_set_i(sb_set_i), .sb_addr_i(sb_addr_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: architectural contents and pending-writeback flags.
  logic [XLEN-1:0] mem [NREGS];
  bit              pend [NREGS];

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      mem[i]  = '0;
      pend[i] = 1'b0;
    end
  endtask

  // Architectural effect of one clock edge, applied in port order so the
  // highest-indexed writer ends up holding the register.
  task automatic model_update();
    for (int w = 0; w < NUM_WR; w++) begin
      int a;
      a = int'(rd_addr_i[w*AW +: AW]);
      if (rd_we_i[w] && a != 0) begin
        mem[a]  = rd_data_i[w*XLEN +: XLEN];
        pend[a] = 1'b0;
      end
    end
    if (sb_set_i && sb_addr_i != 0) pend[int'(sb_addr_i)] = 1'b1;
  endtask

  function automatic logic [XLEN-1:0] exp_data(input int a);
    logic [XLEN-1:0] v;
    if (a == 0) return '0;
    v = mem[a];
`ifdef REGFILE_BYPASS_EN
    for (int w = 0; w < NUM_WR; w++)
      if (rd_we_i[w] && int'(rd_addr_i[w*AW +: AW]) == a) v = rd_data_i[w*XLEN +: XLEN];
`endif
    return v;
  endfunction

  function automatic logic exp_busy(input int a);
    logic b;
    if (a == 0) return 1'b0;
    b = pend[a];
`ifdef REGFILE_BYPASS_EN
    for (int w = 0; w < NUM_WR; w++)
      if (rd_we_i[w] && int'(rd_addr_i[w*AW +: AW]) == a) b = 1'b0;
`endif
    return b;
  endfunction

  task automatic check_model(input string tag);
    for (int p = 0; p < NUM_RD; p++) begin
      int a;
      a = int'(rs_addr_i[p*AW +: AW]);
      check($sformatf("%s_data_p%0d_x%0d", tag, p, a), rs_data_o[p*XLEN +: XLEN], exp_data(a));
      check($sformatf("%s_busy_p%0d_x%0d", tag, p, a), XLEN'(rs_busy_o[p]), XLEN'(exp_busy(a)));
    end
  endtask

  task automatic clear_inputs();
    rd_we_i   = '0;
    rd_addr_i = '0;
    rd_data_i = '0;
    sb_set_i  = 1'b0;
    sb_addr_i = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    rs_addr_i[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int w, input int a, input logic [XLEN-1:0] d);
    rd_we_i[w]                = 1'b1;
    rd_addr_i[w*AW +: AW]     = AW'(a);
    rd_data_i[w*XLEN +: XLEN] = d;
  endtask

  task automatic commit();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic step(input string tag);
    @(negedge clk_i);
    check_model(tag);
    commit();
  endtask

  initial begin
    model_reset();
    clear_inputs();
    rs_addr_i = '0;
    rst_n_i   = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;

    // Reset asserted mid-write: outputs must drop to zero immediately.
    set_wr(0, 5, 32'h1234);
    set_wr(1, 5, 32'h1234);
    sb_set_i = 1'b1; sb_addr_i = 5'd5;
    set_rd(0, 5); set_rd(1, 5);
    @(negedge clk_i);
    #1 rst_n_i = 1'b0;
    model_reset();
    #1;
    check("rst_data_p0", rs_data_o[0 +: XLEN], '0);
    check("rst_data_p1", rs_data_o[XLEN +: XLEN], '0);
    check("rst_busy", XLEN'(rs_busy_o), '0);
    @(posedge clk_i);
    #1 clear_inputs();
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check("rst_x5_after", rs_data_o[0 +: XLEN], '0);
    check_model("rst");
    commit();

    // Basic write and x0 discard.
    set_wr(0, 1, 32'd10);
    step("wr_x1");
    clear_inputs();
    set_wr(1, 0, 32'hDEADBEEF);
    step("wr_x0");
    clear_inputs();
    set_rd(0, 1); set_rd(1, 0);
    @(negedge clk_i);
    check("x1_is_10", rs_data_o[0 +: XLEN], 32'd10);
    check("x0_is_0", rs_data_o[XLEN +: XLEN], '0);
    check("x0_busy_0", XLEN'(rs_busy_o[1]), '0);
    check_model("basic");
    commit();

    // Write collision: highest port wins.
    set_wr(0, 3, 32'hAAAA_AAAA);
    set_wr(1, 3, 32'h5555_5555);
    step("coll");
    clear_inputs();
    set_rd(0, 3);
    @(negedge clk_i);
    check("x3_coll", rs_data_o[0 +: XLEN], 32'h5555_5555);
    commit();

    // Same-cycle write/read of x7.
    set_wr(0, 7, 32'hCAFE_F00D);
    set_rd(1, 7);
    @(negedge clk_i);
`ifdef REGFILE_BYPASS_EN
    check("x7_bypass", rs_data_o[XLEN +: XLEN], 32'hCAFE_F00D);
`else
    check("x7_old", rs_data_o[XLEN +: XLEN], '0);
`endif
    check_model("byp");
    commit();
    clear_inputs();
    @(negedge clk_i);
    check("x7_next", rs_data_o[XLEN +: XLEN], 32'hCAFE_F00D);
    commit();

    // Scoreboard: set, clear by write, then set+write in one cycle.
    set_rd(0, 4); set_rd(1, 4);
    sb_set_i = 1'b1; sb_addr_i = 5'd4;
    step("sb_set");
    clear_inputs();
    @(negedge clk_i);
    check("x4_busy_set", XLEN'(rs_busy_o[0]), 32'd1);
    commit();
    set_wr(1, 4, 32'h44);
    step("sb_clr");
    clear_inputs();
    @(negedge clk_i);
    check("x4_busy_clr", XLEN'(rs_busy_o[0]), '0);
    commit();
    set_wr(0, 4, 32'h4444);
    sb_set_i = 1'b1; sb_addr_i = 5'd4;
    step("sb_both");
    clear_inputs();
    @(negedge clk_i);
    check("x4_busy_both", XLEN'(rs_busy_o[1]), 32'd1);
    check("x4_data_both", rs_data_o[XLEN +: XLEN], 32'h4444);
    commit();

    // Fill x1..x31 with their index, then read on all ports.
    for (int i = 1; i < NREGS; i += NUM_WR) begin
      clear_inputs();
      for (int w = 0; w < NUM_WR; w++)
        if (i + w < NREGS) set_wr(w, i + w, XLEN'(i + w));
      commit();
    end
    clear_inputs();
    for (int i = 0; i < 16; i++) begin
      int a0, a1;
      a0 = $urandom_range(NREGS - 1);
      a1 = (i % 2 == 0) ? a0 : int'($urandom_range(NREGS - 1));
      set_rd(0, a0); set_rd(1, a1);
      @(negedge clk_i);
      check($sformatf("fill_p0_x%0d", a0), rs_data_o[0 +: XLEN], XLEN'(a0));
      check($sformatf("fill_p1_x%0d", a1), rs_data_o[XLEN +: XLEN], XLEN'(a1));
      commit();
    end

    // Randomized traffic against the model; narrow address window half the
    // time to provoke collisions and same-cycle read/write overlaps.
    for (int c = 0; c < 400; c++) begin
      int span;
      span = ($urandom_range(1) == 0) ? 7 : NREGS - 1;
      clear_inputs();
      for (int w = 0; w < NUM_WR; w++)
        if ($urandom_range(2) != 0) set_wr(w, $urandom_range(span), XLEN'($urandom));
      for (int p = 0; p < NUM_RD; p++) set_rd(p, $urandom_range(span));
      sb_set_i  = ($urandom_range(1) == 1);
      sb_addr_i = AW'($urandom_range(span));
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
